// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared state types, the default acknowledgement byte and the baud-divider helper
// used by the UART word receiver and its byte transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  localparam logic [7:0] UART_ACK_DEFAULT = 8'b11001100;

  // Clock cycles per UART bit; integer division truncates toward the faster rate.
  function automatic int calcBitCycles(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction

endpackage

// File: rtl/uart_word_receiver_if.sv
`timescale 1ns/1ps
// Valid/ready word channel between the UART receiver (master, produces words)
// and the memory loader (slave, consumes them).
interface uart_word_receiver_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/uart_tx_byte.sv
`timescale 1ns/1ps
// Single-byte UART transmitter: start bit, UART_WIDTH data bits LSB first, one stop bit.
// A start request is taken only while idle; busy_o covers the whole frame.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = 217,
  parameter int UART_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start_i,
  input  logic [UART_WIDTH-1:0] data_i,
  output logic                  busy_o,
  output logic                  tx_o
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_WIDTH - 1);

  tx_state_t             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      bitIdx_q;
  logic [UART_WIDTH-1:0] shift_q;
  logic                  tx_q;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (start_i) begin
            shift_q <= data_i;
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q    <= '0;
            tx_q     <= shift_q[0];
            shift_q  <= shift_q >> 1;
            bitIdx_q <= '0;
            state_q  <= TX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (bitIdx_q == IDX_LAST) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              tx_q     <= shift_q[0];
              shift_q  <= shift_q >> 1;
              bitIdx_q <= bitIdx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != TX_IDLE);
  assign tx_o   = tx_q;

endmodule

// File: rtl/uart_word_receiver.sv
`timescale 1ns/1ps
// Receives UART bytes, packs NBYTES of them into one word (first byte in the low bits),
// offers the word over valid/ready and answers each accepted word with an ACK byte.
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int                    CLK_FREQ   = 50_000_000,
  parameter int                    BAUD_RATE  = 230400,
  parameter int                    UART_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [UART_WIDTH-1:0] UART_ACK   = UART_WIDTH'(UART_ACK_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rx,
  output logic                 tx,
  uart_word_receiver_if.master bus,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int BIT_CYCLES  = calcBitCycles(CLK_FREQ, BAUD_RATE);
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int NBYTES      = DATA_WIDTH / UART_WIDTH;
  localparam int CNT_W       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W       = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
  localparam int BC_W        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(UART_WIDTH - 1);
  localparam logic [BC_W-1:0]  BYTES_LAST = BC_W'(NBYTES - 1);

  logic                  rxMeta_q, rxSync_q;
  rx_state_t             rxState_q;
  logic [CNT_W-1:0]      rxCnt_q;
  logic [IDX_W-1:0]      rxIdx_q;
  logic [UART_WIDTH-1:0] rxShift_q;
  logic [BC_W-1:0]       byteCnt_q;
  logic [DATA_WIDTH-1:0] wordBuf_q;
  logic                  wordDone_q;
  logic                  framingError_q;
  logic                  breakWait_q;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  pending_q, pending_d;
  logic                  ackReq, startTx, txBusy;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // After a framing error the line may sit low (break); breakWait_q holds IDLE until it returns high.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rxState_q      <= RX_IDLE;
      rxCnt_q        <= '0;
      rxIdx_q        <= '0;
      rxShift_q      <= '0;
      byteCnt_q      <= '0;
      wordBuf_q      <= '0;
      wordDone_q     <= 1'b0;
      framingError_q <= 1'b0;
      breakWait_q    <= 1'b0;
    end else begin
      wordDone_q     <= 1'b0;
      framingError_q <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (breakWait_q) begin
            if (rxSync_q) breakWait_q <= 1'b0;
          end else if (!rxSync_q) begin
            rxCnt_q   <= '0;
            rxState_q <= RX_START;
          end
        end
        RX_START: begin
          if (rxCnt_q == HALF_LAST) begin
            rxCnt_q   <= '0;
            rxIdx_q   <= '0;
            rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rxCnt_q == BIT_LAST) begin
            rxCnt_q   <= '0;
            rxShift_q <= {rxSync_q, rxShift_q[UART_WIDTH-1:1]};
            if (rxIdx_q == IDX_LAST) rxState_q <= RX_STOP;
            else                     rxIdx_q   <= rxIdx_q + 1'b1;
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (rxCnt_q == BIT_LAST) begin
            rxCnt_q   <= '0;
            rxState_q <= RX_IDLE;
            if (rxSync_q) begin
              wordBuf_q <= {rxShift_q, wordBuf_q[DATA_WIDTH-1:UART_WIDTH]};
              if (byteCnt_q == BYTES_LAST) begin
                byteCnt_q  <= '0;
                wordDone_q <= 1'b1;
              end else begin
                byteCnt_q <= byteCnt_q + 1'b1;
              end
            end else begin
              framingError_q <= 1'b1;
              byteCnt_q      <= '0;
              breakWait_q    <= 1'b1;
            end
          end else begin
            rxCnt_q <= rxCnt_q + 1'b1;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  // A word finishing on the consume edge counts as accepted, so ready frees the slot early.
  always_comb begin
    ackReq    = wordDone_q && (!valid_q || bus.data_ready);
    startTx   = !txBusy && (pending_q || ackReq);
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    pending_d = pending_q;
    if (wordDone_q) begin
      if (ackReq) begin
        data_d  = wordBuf_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end
    if (ackReq && (txBusy || pending_q)) pending_d = 1'b1;
    else if (startTx)                    pending_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
    end
  end

  uart_tx_byte #(
    .BIT_CYCLES (BIT_CYCLES),
    .UART_WIDTH (UART_WIDTH)
  ) u_ackTx (
    .clk     (clk),
    .rstN    (rstN),
    .start_i (startTx),
    .data_i  (UART_ACK),
    .busy_o  (txBusy),
    .tx_o    (tx)
  );

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign framing_error  = framingError_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_word_receiver.sv
`timescale 1ns/1ps
// Directed bench for uart_word_receiver: drives UART frames, keeps a word/ACK/error model
// at transaction level and checks the DUT against it every cycle, plus literal anchors.
module tb_uart_word_receiver;

  localparam int         BIT  = 217;
  localparam int         HALF = 108;
  localparam logic [7:0] ACK  = 8'hCC;

  logic clk;
  logic rstN;
  logic rx;
  logic tx;
  logic fe;
  logic ov;

  uart_word_receiver_if #(.DATA_WIDTH(16)) busIf ();

  uart_word_receiver #(
    .CLK_FREQ   (50_000_000),
    .BAUD_RATE  (230400),
    .UART_WIDTH (8),
    .DATA_WIDTH (16),
    .UART_ACK   (8'b11001100)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .rx            (rx),
    .tx            (tx),
    .bus           (busIf),
    .framing_error (fe),
    .overrun       (ov)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  int nCompared   = 0;
  int nMismatched = 0;

  logic [7:0]  rxBytes[$];
  logic [15:0] expWords[$];
  logic [9:0]  txQ[$];
  logic [15:0] lastPushed   = '0;
  logic [15:0] lastWordSeen = '0;
  int expAcks = 0, expFe = 0, expOv = 0;
  int seenAcks = 0, seenFe = 0, seenOv = 0, validRises = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model of the receive side: bytes pair up into a word, a held unconsumed word causes a drop.
  task automatic modelFrame(input logic [7:0] value, input logic stopBit);
    logic [15:0] w;
    if (!stopBit) begin
      expFe++;
      rxBytes.delete();
    end else begin
      rxBytes.push_back(value);
      if (rxBytes.size() == 2) begin
        w = {rxBytes[1], rxBytes[0]};
        rxBytes.delete();
        lastPushed = w;
        if (expWords.size() > 0 && !busIf.data_ready) begin
          expOv++;
        end else begin
          expWords.push_back(w);
          expAcks++;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = value[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rx = stopBit;
    modelFrame(value, stopBit);
    repeat (BIT) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic waitValid(input int maxCycles, input string name);
    int n;
    n = 0;
    while (!busIf.data_valid && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!busIf.data_valid) checkOutput(name, busIf.data_valid, 1);
  endtask

  task automatic waitAcks(input int maxCycles, input string name);
    int n;
    n = 0;
    while (seenAcks < expAcks && n < maxCycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (seenAcks < expAcks) checkOutput(name, seenAcks, expAcks);
  endtask

  task automatic consumeWord(input string name);
    @(posedge clk);
    #1 busIf.data_ready = 1'b1;
    @(posedge clk);
    #1 checkOutput(name, busIf.data_valid, 0);
    busIf.data_ready = 1'b0;
  endtask

  // Decode every frame seen on tx by mid-bit sampling; the compare process judges it.
  initial begin : txMonitor
    logic [7:0] b;
    logic startSample, stopSample;
    forever begin
      @(negedge clk);
      if (rstN && tx === 1'b0) begin
        repeat (HALF) @(negedge clk);
        startSample = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        stopSample = tx;
        txQ.push_back({startSample, stopSample, b});
      end
    end
  end

  initial begin : compareProc
    logic prevValid, prevFe, prevOv;
    logic [9:0] f;
    prevValid = 1'b0;
    prevFe    = 1'b0;
    prevOv    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prevValid = 1'b0;
        prevFe    = 1'b0;
        prevOv    = 1'b0;
      end else begin
        if (busIf.data_valid) begin
          if (!prevValid) begin
            validRises++;
            lastWordSeen = busIf.data;
          end
          if (expWords.size() == 0) begin
            checkOutput("valid without expected word", busIf.data_valid, 0);
          end else begin
            if (!prevValid) checkOutput("data at valid rise", busIf.data, expWords[0]);
            else            checkOutput("data while held", busIf.data, expWords[0]);
            if (busIf.data_ready) void'(expWords.pop_front());
          end
        end
        if (fe) begin
          seenFe++;
          checkOutput("framing_error width", prevFe, 0);
        end
        if (ov) begin
          seenOv++;
          checkOutput("overrun width", prevOv, 0);
        end
        while (txQ.size() > 0) begin
          f = txQ.pop_front();
          seenAcks++;
          checkOutput("ack byte", f[7:0], ACK);
          checkOutput("ack start bit", f[9], 0);
          checkOutput("ack stop bit", f[8], 1);
        end
        prevValid = busIf.data_valid;
        prevFe    = fe;
        prevOv    = ov;
      end
    end
  end

  initial begin : watchdog
    repeat (95000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int r0, o0;
    rx               = 1'b1;
    busIf.data_ready = 1'b0;
    rstN             = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset tx", tx, 1);
    checkOutput("reset data", busIf.data, 0);
    checkOutput("reset valid", busIf.data_valid, 0);
    checkOutput("reset framing_error", fe, 0);
    checkOutput("reset overrun", ov, 0);
    rstN = 1'b1;
    repeat (5) @(posedge clk);

    // Word 0x0002 held with ready low, ACK expected.
    applyStimulus(8'h02, 1'b1);
    applyStimulus(8'h00, 1'b1);
    waitValid(500, "t1 valid timeout");
    checkOutput("t1 model word", lastPushed, 16'h0002);
    checkOutput("t1 data", busIf.data, 16'h0002);
    checkOutput("t1 valid", busIf.data_valid, 1);
    waitAcks(3000, "t1 ack timeout");
    checkOutput("t1 ack count", seenAcks, 1);
    repeat (1000) @(posedge clk);
    #1 checkOutput("t1 valid after 1000", busIf.data_valid, 1);

    // Overrun: second word dropped while the first is held.
    applyStimulus(8'h34, 1'b1);
    applyStimulus(8'h12, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    checkOutput("t2 overrun vs model", seenOv, expOv);
    checkOutput("t2 overrun count", seenOv, 1);
    checkOutput("t2 data kept", busIf.data, 16'h0002);
    repeat (2500) @(posedge clk);
    #1;
    checkOutput("t2 ack vs model", seenAcks, expAcks);
    checkOutput("t2 no second ack", seenAcks, 1);
    consumeWord("t2 valid cleared");

    // Framing error discards the partial word.
    applyStimulus(8'hAA, 1'b0);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("t3 framing vs model", seenFe, expFe);
    checkOutput("t3 framing count", seenFe, 1);
    checkOutput("t3 no valid", busIf.data_valid, 0);
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'h66, 1'b1);
    waitValid(500, "t3 valid timeout");
    checkOutput("t3 data", busIf.data, 16'h6655);
    waitAcks(3000, "t3 ack timeout");
    consumeWord("t3 valid cleared");

    // Short low glitch must not start a frame.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (50) @(posedge clk);
    #1 rx = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    checkOutput("t4 glitch valid", busIf.data_valid, 0);
    checkOutput("t4 glitch framing", seenFe, expFe);
    checkOutput("t4 glitch overrun", seenOv, expOv);
    applyStimulus(8'hEF, 1'b1);
    applyStimulus(8'hBE, 1'b1);
    waitValid(500, "t4 valid timeout");
    checkOutput("t4 data", busIf.data, 16'hBEEF);
    waitAcks(3000, "t4 ack timeout");
    consumeWord("t4 valid cleared");

    // Reset during bit 3 of the second byte.
    applyStimulus(8'h11, 1'b1);
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      #1 rx = i[0];
      repeat (BIT) @(posedge clk);
    end
    #1 rx = 1'b0;
    repeat (BIT / 2) @(posedge clk);
    #5 rstN = 1'b0;
    rxBytes.delete();
    expWords.delete();
    #1;
    checkOutput("t5 reset tx", tx, 1);
    checkOutput("t5 reset data", busIf.data, 0);
    checkOutput("t5 reset valid", busIf.data_valid, 0);
    checkOutput("t5 reset framing_error", fe, 0);
    checkOutput("t5 reset overrun", ov, 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rstN = 1'b1;
    repeat (300) @(posedge clk);
    applyStimulus(8'h78, 1'b1);
    applyStimulus(8'h56, 1'b1);
    waitValid(500, "t5 valid timeout");
    checkOutput("t5 data", busIf.data, 16'h5678);
    waitAcks(3000, "t5 ack timeout");
    consumeWord("t5 valid cleared");

    // Back-to-back words with ready held high.
    @(posedge clk);
    #1 busIf.data_ready = 1'b1;
    r0 = validRises;
    o0 = seenOv;
    applyStimulus(8'hA1, 1'b1);
    applyStimulus(8'hB2, 1'b1);
    applyStimulus(8'hC3, 1'b1);
    applyStimulus(8'hD4, 1'b1);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("t6 valid pulses", validRises - r0, 2);
    checkOutput("t6 no overrun", seenOv, o0);
    checkOutput("t6 last word", lastWordSeen, 16'hD4C3);
    waitAcks(3000, "t6 ack timeout");
    checkOutput("t6 ack vs model", seenAcks, expAcks);
    checkOutput("t6 total acks", seenAcks, 6);
    busIf.data_ready = 1'b0;

    checkOutput("final framing total", seenFe, 1);
    checkOutput("final overrun total", seenOv, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/uart_word_receiver.md
# uart_word_receiver

Receives external data over the UART line on the GPIO receive pin of the external-communication path. Assembles consecutive 8-bit frames into one DATA_WIDTH word and hands it to the master write-side logic through a valid/ready handshake. For every accepted word, it transmits the fixed acknowledgement byte on the paired GPIO transmit pin. It is the stage directly downstream of the board-level rx wire and upstream of the master memory loader.

## Interface
- CLK_FREQ, 50_000_000: clk frequency in Hz
- BAUD_RATE, 230400: line rate
- UART_WIDTH, 8: data bits per frame
- DATA_WIDTH, 16: output word width; must be a multiple of UART_WIDTH
- UART_ACK, 8'b11001100: byte sent back after each stored word
- clk  input  1  system clock
- rstN  input  1  asynchronous, active-low reset
- rx  input  1  UART line in, asynchronous to clk, idle high
- tx  output  1  UART line out, idle high
- data  output  DATA_WIDTH  assembled word; first received byte lands in bits [7:0]
- data_valid  output  1  word held on data
- data_ready  input  1  consumer accepts data
- framing_error  output  1  one-cycle pulse on a bad stop bit
- overrun  output  1  one-cycle pulse when a completed word is dropped

## Operation
- BIT_CYCLES = CLK_FREQ/BAUD_RATE, integer division, giving 217. HALF_CYCLES = BIT_CYCLES/2, giving 108. NBYTES = DATA_WIDTH/UART_WIDTH.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value.
- RX FSM has four states:
  - IDLE: a synced low moves to START.
  - START: wait HALF_CYCLES, then re-sample. If low, go to DATA; if high (glitch), go to IDLE with nothing recorded.
  - DATA: sample every BIT_CYCLES, UART_WIDTH bits, LSB first.
  - STOP: sample after BIT_CYCLES.
- Stop bit = 1: the byte is shifted into the word buffer and the byte counter is incremented. When the counter reaches NBYTES, the word is complete and the counter wraps to 0.
- Stop bit = 0: pulse framing_error, discard the partial word (byte counter cleared), and wait for synced rx high before entering IDLE.
- Word complete with data_valid low: load data, set data_valid, and request an ACK.
- Word complete with data_valid high: the held word is kept, the new word is dropped, overrun pulses, and no ACK is sent.
- data_valid clears on the clk edge where data_valid && data_ready. A word completing on that same edge is stored, not flagged as overrun.
- TX FSM states are IDLE, START, DATA, STOP, each lasting BIT_CYCLES. It sends UART_ACK LSB first. tx is registered.
- An ACK request raised while TX is busy sets a single pending flag, and the ACK is sent after the current frame.

## Timing
- Reset values: tx=1, data=0, data_valid=0, framing_error=0, overrun=0. Both FSMs are in IDLE, counters are 0, pending is 0.
- Reset asserted mid-frame aborts both FSMs immediately. tx returns high asynchronously.
- Byte-complete edge falls 2 + HALF_CYCLES + (UART_WIDTH+1)·BIT_CYCLES clk after the rx falling edge, ±1 clk for synchronizer phase.
- data_valid rises 1 clk after the final byte-complete edge.
- tx start bit begins on the same edge data_valid rises.
- ACK frame lasts (UART_WIDTH+2)·BIT_CYCLES = 2170 clk.
- framing_error and overrun are exactly 1 clk wide.
- rx and tx paths are independent; receiving continues while ACK transmits.

## Structure
- Package uart_pkg holds:
  - the rx_state_t and tx_state_t enums
  - the UART_ACK default constant
  - a function computing BIT_CYCLES from CLK_FREQ and BAUD_RATE
- One sub-module, uart_tx_byte (TX FSM, bit counter, shift register, start/busy handshake), instantiated for the ACK. It is reusable by the data transmitter.

## Test plan
- Frames 0x02 then 0x00 at 230400 baud, data_ready=0:
  - data=16'h0002 and data_valid=1.
  - tx carries a frame decoding to 8'b11001100.
  - data_valid is still 1 after 1000 clk.
- Word held with data_ready=0, then frames 0x34, 0x12:
  - overrun pulses once.
  - data stays 16'h0002 and no second ACK appears.
  - Raising data_ready then clears data_valid next edge.
- Frame 0xAA with stop bit forced 0:
  - framing_error pulses.
  - Next frames 0x55, 0x66 give data=16'h6655. The partial 0xAA is discarded.
- rx low pulse of 50 clk:
  - no state change, no valid, no error.
  - Following word 0xBEEF (0xEF then 0xBE) is received correctly.
- rstN low during bit 3 of the second byte:
  - all outputs are at reset values within 1 clk.
  - Next full word is received correctly from byte 0.
- Two words back-to-back with data_ready=1:
  - two data_valid pulses with correct values.
  - two complete ACK frames on tx, no overrun.
